// File: rtl/pipe_pkg.sv
// Shared constants and types for the inter-stage pipeline registers.
// Used by pipe_entry and pipe_stage_reg; the skid state type is only needed when PIPE_REG_SKID_EN is defined.
package pipe_pkg;

   // Bit positions within the control bundle.
   localparam int CTRL_W        = 6;
   localparam int CTRL_ZERO     = 0;
   localparam int CTRL_REGWR    = 1;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_JUMP     = 3;
   localparam int CTRL_MEMWR    = 4;
   localparam int CTRL_MEMTOREG = 5;

   // Payload widths at each stage boundary.
   localparam int IDEX_DATA_W  = 106;
   localparam int EXMEM_DATA_W = 69;
   localparam int MEMWB_DATA_W = 69;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skidState_t;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: a valid bit, a payload and a control bundle.
// A clear empties the entry and zeroes its control bits but leaves the payload stale.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int DATA_W = EXMEM_DATA_W,
   parameter int CW     = CTRL_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CW-1:0]     i_ctrl,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [CW-1:0]     o_ctrl
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CW-1:0]     r_ctrl;

   // Control is stored pre-masked so a bubble never carries live control bits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ctrl  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         r_data  <= i_data;
         r_ctrl  <= i_valid ? i_ctrl : '0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall and flush.
// Define PIPE_REG_SKID_EN to add a skid entry that makes in_ready a registered signal.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = EXMEM_DATA_W,
   parameter int CTRL_W = pipe_pkg::CTRL_W
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   logic              w_mLoad;
   logic              w_mValid;
   logic [DATA_W-1:0] w_mData;
   logic [CTRL_W-1:0] w_mCtrl;
   logic              w_mInValid;
   logic [DATA_W-1:0] w_mInData;
   logic [CTRL_W-1:0] w_mInCtrl;

   // M takes a new value whenever it is empty or its occupant leaves this cycle.
   assign w_mLoad = !w_mValid || out_ready;

   pipe_entry #(.DATA_W(DATA_W), .CW(CTRL_W)) u_main (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_clear (flush),
      .i_load  (w_mLoad),
      .i_valid (w_mInValid),
      .i_data  (w_mInData),
      .i_ctrl  (w_mInCtrl),
      .o_valid (w_mValid),
      .o_data  (w_mData),
      .o_ctrl  (w_mCtrl)
   );

`ifdef PIPE_REG_SKID_EN
   skidState_t        r_state;
   skidState_t        w_nextState;
   logic              w_inReady;
   logic              w_selS;
   logic              w_sLoad;
   logic              w_sClear;
   logic              w_sValid;
   logic [DATA_W-1:0] w_sData;
   logic [CTRL_W-1:0] w_sCtrl;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= SKID_EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (flush) begin
         w_nextState = SKID_EMPTY;
      end else begin
         case (r_state)
            SKID_EMPTY: if (in_valid) w_nextState = SKID_ONE;
            SKID_ONE: begin
               if (out_ready && !in_valid)      w_nextState = SKID_EMPTY;
               else if (!out_ready && in_valid) w_nextState = SKID_FULL;
            end
            SKID_FULL:  if (out_ready) w_nextState = SKID_ONE;
            default:    w_nextState = SKID_EMPTY;
         endcase
      end
   end

   // S catches the item accepted while M is stalled and refills M once it drains.
   always_comb begin
      w_inReady = (r_state != SKID_FULL);
      w_selS    = (r_state == SKID_FULL);
      w_sLoad   = (r_state == SKID_ONE) && !out_ready && in_valid;
      w_sClear  = flush || ((r_state == SKID_FULL) && out_ready);
   end

   pipe_entry #(.DATA_W(DATA_W), .CW(CTRL_W)) u_skid (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_clear (w_sClear),
      .i_load  (w_sLoad),
      .i_valid (in_valid),
      .i_data  (in_data),
      .i_ctrl  (in_ctrl),
      .o_valid (w_sValid),
      .o_data  (w_sData),
      .o_ctrl  (w_sCtrl)
   );

   assign in_ready   = w_inReady;
   assign w_mInValid = w_selS ? w_sValid : in_valid;
   assign w_mInData  = w_selS ? w_sData  : in_data;
   assign w_mInCtrl  = w_selS ? w_sCtrl  : in_ctrl;
`else
   assign in_ready   = w_mLoad;
   assign w_mInValid = in_valid;
   assign w_mInData  = in_data;
   assign w_mInCtrl  = in_ctrl;
`endif

   assign out_valid = w_mValid;
   assign out_data  = w_mData;
   assign out_ctrl  = w_mCtrl & {CTRL_W{w_mValid}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic checked against a FIFO-style model.
// The model capacity follows PIPE_REG_SKID_EN so the same bench covers both builds.
module tb_pipe_stage_reg;

   localparam int DW = 69;
   localparam int CW = 6;
`ifdef PIPE_REG_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct {
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
   } item_t;

   logic          Clk;
   logic          Rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;

   int    vectors;
   int    miscompares;
   item_t q[$];

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The stage behaves as a FIFO of capacity CAP; without skid it may also accept while its occupant leaves.
   function automatic logic modelReady(input logic ordy);
      if (CAP == 1) return (q.size() == 0) || ordy;
      return q.size() < CAP;
   endfunction

   task automatic checkOutput(input string tag);
      checkVal({tag, ".in_ready"}, {127'd0, in_ready}, {127'd0, modelReady(out_ready)});
      checkVal({tag, ".out_valid"}, {127'd0, out_valid}, {127'd0, q.size() > 0});
      if (q.size() > 0) begin
         checkVal({tag, ".out_ctrl"}, {122'd0, out_ctrl}, {122'd0, q[0].ctrl});
         checkVal({tag, ".out_data"}, {59'd0, out_data}, {59'd0, q[0].data});
      end else begin
         checkVal({tag, ".out_ctrl"}, {122'd0, out_ctrl}, 128'd0);
      end
   endtask

   // Called just after a falling edge: drive, check, take the rising edge, advance the model.
   task automatic applyStimulus(input string tag, input logic iv, input logic [DW-1:0] d,
                                input logic [CW-1:0] c, input logic ordy, input logic fl);
      logic acc;
      logic pop;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      #1;
      checkOutput(tag);
      acc = iv && modelReady(ordy);
      pop = (q.size() > 0) && ordy;
      @(posedge Clk);
      if (fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back('{data: d, ctrl: c});
      end
      @(negedge Clk);
   endtask

   function automatic logic [DW-1:0] randData();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      Rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      in_ctrl     = '0;
      out_ready   = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      checkVal("rst.out_valid", {127'd0, out_valid}, 128'd0);
      checkVal("rst.out_ctrl", {122'd0, out_ctrl}, 128'd0);
      checkVal("rst.out_data", {59'd0, out_data}, 128'd0);
      Rst_n = 1'b1;
      #1;
      checkVal("rst.in_ready", {127'd0, in_ready}, 128'd1);

      // Reset asserted mid-stall must empty the stage without a clock edge.
      applyStimulus("rstload", 1'b1, 69'h1_2345_6789, 6'h3F, 1'b0, 1'b0);
      applyStimulus("rststall", 1'b0, '0, '0, 1'b0, 1'b0);
      #2;
      Rst_n = 1'b0;
      #1;
      q.delete();
      checkVal("midrst.out_valid", {127'd0, out_valid}, 128'd0);
      checkVal("midrst.out_ctrl", {122'd0, out_ctrl}, 128'd0);
      checkVal("midrst.out_data", {59'd0, out_data}, 128'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      checkVal("midrst.in_ready", {127'd0, in_ready}, 128'd1);
      @(negedge Clk);

      for (int i = 1; i <= 8; i++)
         applyStimulus("stream", 1'b1, DW'(i), CW'($urandom), 1'b1, 1'b0);
      applyStimulus("streamdrain", 1'b0, '0, '0, 1'b1, 1'b0);

      applyStimulus("stall.load", 1'b1, DW'(5), 6'h12, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus("stall.hold", 1'b1, DW'(6), 6'h21, 1'b0, 1'b0);
      applyStimulus("stall.rel", 1'b0, '0, 6'h3F, 1'b1, 1'b0);
      applyStimulus("stall.rel", 1'b0, '0, 6'h3F, 1'b1, 1'b0);
      applyStimulus("stall.rel", 1'b0, '0, 6'h3F, 1'b1, 1'b0);

      applyStimulus("bubble", 1'b1, DW'(10), 6'h01, 1'b1, 1'b0);
      applyStimulus("bubble", 1'b0, DW'(11), 6'h3F, 1'b1, 1'b0);
      applyStimulus("bubble", 1'b1, DW'(12), 6'h02, 1'b1, 1'b0);
      applyStimulus("bubble", 1'b0, '0, '0, 1'b1, 1'b0);

      applyStimulus("flush.fill", 1'b1, DW'(20), 6'h0F, 1'b0, 1'b0);
      applyStimulus("flush.fill", 1'b1, DW'(21), 6'h1F, 1'b0, 1'b0);
      applyStimulus("flush", 1'b1, DW'(22), 6'h3F, 1'b0, 1'b1);
      applyStimulus("flush.after", 1'b0, '0, '0, 1'b1, 1'b0);
      applyStimulus("flush.after", 1'b0, '0, '0, 1'b1, 1'b0);

      applyStimulus("simul", 1'b1, DW'(8), 6'h04, 1'b1, 1'b0);
      applyStimulus("simul", 1'b1, DW'(9), 6'h08, 1'b1, 1'b0);
      applyStimulus("simul", 1'b0, '0, '0, 1'b1, 1'b0);
      applyStimulus("simul", 1'b0, '0, '0, 1'b1, 1'b0);

      for (int i = 0; i < 400; i++)
         applyStimulus("rand", 1'($urandom_range(0, 3) != 0), randData(), CW'($urandom),
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
